id_stage: RTL
=============

# id_stage

Instruction-decode stage of the five-stage pipelined MIPS core. It sits directly downstream of the fetch stage: it consumes the IF/ID register outputs (PC+4 and instruction) and returns the PC-source, branch/jump target, flush, IF/ID write-enable and PC-write controls to fetch. Internally it holds the 32×32 register file, resolves branches and jumps in ID, detects load-use and branch-operand hazards, and drives the registered ID/EX pipeline register.

## Interface
- No parameters; widths fixed at 32-bit data and 5-bit register addresses.
- i_clk  in  1  rising-edge clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_pc_plus4  in  32  IF/ID PC+4.
- i_instr  in  32  IF/ID instruction.
- i_wb_we, i_wb_addr, i_wb_data  in  1/5/32  write-back port.
- i_exmem_reg_write, i_exmem_mem_read, i_exmem_dst, i_exmem_result  in  1/1/5/32  EX/MEM state for branch hazards and forwarding.
- o_pc_src  out  1  branch taken, to fetch.
- o_branch_addr  out  32  branch target.
- o_jump  out  1  `j` decoded, to fetch.
- o_jump_addr  out  32  jump target.
- o_flush  out  1  flush IF/ID on a taken branch.
- o_ifid_wen  out  1  IF/ID write enable.
- o_pc_write  out  1  PC write enable.
- o_ex_pc_plus4, o_ex_rs_data, o_ex_rt_data, o_ex_imm  out  32 each  ID/EX datapath.
- o_ex_rs, o_ex_rt, o_ex_rd  out  5 each  ID/EX register numbers.
- o_ex_reg_write, o_ex_mem_to_reg, o_ex_mem_read, o_ex_mem_write, o_ex_alu_src, o_ex_reg_dst  out  1 each  ID/EX control.
- o_ex_alu_op  out  2  ID/EX ALU op class.

## Operation
- Decode: R-type (op 0x00): reg_write, reg_dst, alu_op=10. lw (0x23): reg_write, mem_to_reg, mem_read, alu_src, alu_op=00. sw (0x2B): mem_write, alu_src, alu_op=00. addi (0x08): reg_write, alu_src, alu_op=00. beq (0x04), bne (0x05), j (0x02): resolved in ID, all EX controls 0. Any other opcode: all controls 0.
- o_ex_imm = sign-extended instr[15:0]; o_branch_addr = i_pc_plus4 + (imm << 2), modulo 2^32; o_jump_addr = {i_pc_plus4[31:28], instr[25:0], 2'b00}.
- Register file: r0 reads 0, writes to r0 ignored; write on rising edge when i_wb_we. Read is combinational with write-through bypass: a same-cycle write to the read address returns i_wb_data.
- Load-use stall: ID/EX mem_read=1, ID/EX rt≠0, and ID/EX rt equals instr rs or rt.
- Branch stall (beq/bne only): ID/EX reg_write=1 with destination (rd if reg_dst else rt) ≠0 matching rs or rt; or EX/MEM mem_read=1, reg_write=1, dst≠0 matching rs or rt.
- On stall: o_pc_write=0, o_ifid_wen=0, o_pc_src=0, o_jump=0, o_flush=0; ID/EX loads a bubble (all control 0).
- No stall: o_pc_write=1, o_ifid_wen=1. beq taken when operands equal, bne when unequal; taken sets o_pc_src=1 and o_flush=1. j sets o_jump=1, o_flush=0; fetch ORs jump into its flush.
- o_pc_src and o_jump are never both 1.

## Timing
- Fetch controls (o_pc_src, o_jump, o_flush, o_ifid_wen, o_pc_write, targets): combinational, valid in the same cycle the instruction is in IF/ID.
- ID/EX outputs: registered, one-cycle latency.
- A load-use hazard stalls 1 cycle. A branch after a dependent ALU op stalls 1 cycle. A branch after a dependent load stalls 2 cycles: load-use first, then EX/MEM load.
- Reset, applied at the rising edge: all 31 registers and all ID/EX outputs clear to 0. Asserting reset mid-stall discards the stall; the next cycle decodes whatever IF/ID holds.
- Write-back and decode of the same register in the same cycle use the bypassed new value.

## Configuration
- ID_BRANCH_FWD_EN defined: an EX/MEM non-load result (reg_write=1, mem_read=0, dst≠0) matching a branch operand is forwarded from i_exmem_result into the comparator, with no stall.
- ID_BRANCH_FWD_EN undefined: any EX/MEM reg_write match on a branch operand stalls 1 cycle. Other behaviour is identical.

## Test plan
- Reset, then `addi r1,r0,5` at pc_plus4=0x4 -> next cycle o_ex_reg_write=1, o_ex_alu_src=1, o_ex_imm=5, o_ex_rt=1; every output 0 while i_rst=1.
- `lw r2,0(r1)` followed by `add r3,r2,r2` -> exactly 1 cycle with o_pc_write=0, o_ifid_wen=0 and an ID/EX bubble, then add issues normally.
- r4=r5=7 in the register file, `beq r4,r5,+3` at pc_plus4=0x100 -> o_pc_src=1, o_flush=1, o_branch_addr=0x10C. `bne` with the same operands -> o_pc_src=0.
- `j 0x0000040` at pc_plus4=0x80000004 -> o_jump=1, o_jump_addr=0x80000100, o_flush=0.
- `add r6,..` in EX/MEM (result 9), `beq r6,r7` with r7=9 -> with ID_BRANCH_FWD_EN: taken, no stall. Without it: 1 stall cycle, then taken.
- Write-back r8=0xDEADBEEF in the same cycle ID reads r8 -> o_ex_rs_data=0xDEADBEEF next cycle. A write to r0 -> r0 still reads 0.

Source files
------------

// File: rtl/id_stage.sv
// MIPS ID stage: decode, 32x32 regfile, branch/jump resolve, hazards (ID_BRANCH_FWD_EN = EX/MEM forward into branch compare).
// Latency: fetch controls and targets are combinational; ID/EX outputs register on the next rising edge.
// Backpressure: a hazard drops o_pc_write/o_ifid_wen and loads a control bubble into ID/EX.
module id_stage (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [31:0] i_pc_plus4,
   input  logic [31:0] i_instr,
   input  logic        i_wb_we,
   input  logic [4:0]  i_wb_addr,
   input  logic [31:0] i_wb_data,
   input  logic        i_exmem_reg_write,
   input  logic        i_exmem_mem_read,
   input  logic [4:0]  i_exmem_dst,
   input  logic [31:0] i_exmem_result,
   output logic        o_pc_src,
   output logic [31:0] o_branch_addr,
   output logic        o_jump,
   output logic [31:0] o_jump_addr,
   output logic        o_flush,
   output logic        o_ifid_wen,
   output logic        o_pc_write,
   output logic [31:0] o_ex_pc_plus4,
   output logic [31:0] o_ex_rs_data,
   output logic [31:0] o_ex_rt_data,
   output logic [31:0] o_ex_imm,
   output logic [4:0]  o_ex_rs,
   output logic [4:0]  o_ex_rt,
   output logic [4:0]  o_ex_rd,
   output logic        o_ex_reg_write,
   output logic        o_ex_mem_to_reg,
   output logic        o_ex_mem_read,
   output logic        o_ex_mem_write,
   output logic        o_ex_alu_src,
   output logic        o_ex_reg_dst,
   output logic [1:0]  o_ex_alu_op
);

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_J     = 6'h02;

   typedef struct packed {
      logic       reg_write;
      logic       mem_to_reg;
      logic       mem_read;
      logic       mem_write;
      logic       alu_src;
      logic       reg_dst;
      logic [1:0] alu_op;
   } ctrl_t;

   logic [5:0]  opcode;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [31:0] imm;
   logic        is_beq;
   logic        is_bne;
   logic        is_branch;
   logic        is_j;
   ctrl_t       dec_ctrl;

   assign opcode    = i_instr[31:26];
   assign rs        = i_instr[25:21];
   assign rt        = i_instr[20:16];
   assign rd        = i_instr[15:11];
   assign imm       = {{16{i_instr[15]}}, i_instr[15:0]};
   assign is_beq    = (opcode == OP_BEQ);
   assign is_bne    = (opcode == OP_BNE);
   assign is_branch = is_beq | is_bne;
   assign is_j      = (opcode == OP_J);

   always_comb begin
      dec_ctrl = '0;
      case (opcode)
         OP_RTYPE: begin
            dec_ctrl.reg_write = 1'b1;
            dec_ctrl.reg_dst   = 1'b1;
            dec_ctrl.alu_op    = 2'b10;
         end
         OP_LW: begin
            dec_ctrl.reg_write  = 1'b1;
            dec_ctrl.mem_to_reg = 1'b1;
            dec_ctrl.mem_read   = 1'b1;
            dec_ctrl.alu_src    = 1'b1;
         end
         OP_SW: begin
            dec_ctrl.mem_write = 1'b1;
            dec_ctrl.alu_src   = 1'b1;
         end
         OP_ADDI: begin
            dec_ctrl.reg_write = 1'b1;
            dec_ctrl.alu_src   = 1'b1;
         end
         default: ;
      endcase
   end

   // Register file; r0 is never written so it always reads back zero.
   logic [31:0] regs [32];
   logic [31:0] rs_data;
   logic [31:0] rt_data;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else if (i_wb_we && (i_wb_addr != 5'd0)) begin
         regs[i_wb_addr] <= i_wb_data;
      end
   end

   assign rs_data = (rs == 5'd0) ? 32'd0 :
                    (i_wb_we && (i_wb_addr == rs)) ? i_wb_data : regs[rs];
   assign rt_data = (rt == 5'd0) ? 32'd0 :
                    (i_wb_we && (i_wb_addr == rt)) ? i_wb_data : regs[rt];

   ctrl_t       ex_ctrl;
   logic [31:0] ex_pc_plus4;
   logic [31:0] ex_rs_data;
   logic [31:0] ex_rt_data;
   logic [31:0] ex_imm;
   logic [4:0]  ex_rs;
   logic [4:0]  ex_rt;
   logic [4:0]  ex_rd;

   logic [4:0]  ex_dst;
   logic        load_use;
   logic        idex_br_hz;
   logic        exmem_hit_rs;
   logic        exmem_hit_rt;
   logic        exmem_br_hz;
   logic [31:0] rs_cmp;
   logic [31:0] rt_cmp;
   logic        stall;
   logic        go;
   logic        br_taken;

   assign ex_dst     = ex_ctrl.reg_dst ? ex_rd : ex_rt;
   assign load_use   = ex_ctrl.mem_read && (ex_rt != 5'd0) && ((ex_rt == rs) || (ex_rt == rt));
   assign idex_br_hz = is_branch && ex_ctrl.reg_write && (ex_dst != 5'd0) &&
                       ((ex_dst == rs) || (ex_dst == rt));

   assign exmem_hit_rs = i_exmem_reg_write && (i_exmem_dst != 5'd0) && (i_exmem_dst == rs);
   assign exmem_hit_rt = i_exmem_reg_write && (i_exmem_dst != 5'd0) && (i_exmem_dst == rt);

`ifdef ID_BRANCH_FWD_EN
   // Only a load in EX/MEM has no value yet; ALU results are forwarded into the comparator.
   assign exmem_br_hz = is_branch && i_exmem_mem_read && (exmem_hit_rs || exmem_hit_rt);
   assign rs_cmp      = (exmem_hit_rs && !i_exmem_mem_read) ? i_exmem_result : rs_data;
   assign rt_cmp      = (exmem_hit_rt && !i_exmem_mem_read) ? i_exmem_result : rt_data;
`else
   logic unused_exmem;
   assign unused_exmem = ^{i_exmem_result, i_exmem_mem_read};
   assign exmem_br_hz  = is_branch && (exmem_hit_rs || exmem_hit_rt);
   assign rs_cmp       = rs_data;
   assign rt_cmp       = rt_data;
`endif

   assign stall    = load_use | idex_br_hz | exmem_br_hz;
   assign go       = !i_rst && !stall;
   assign br_taken = (is_beq && (rs_cmp == rt_cmp)) || (is_bne && (rs_cmp != rt_cmp));

   assign o_pc_write    = go;
   assign o_ifid_wen    = go;
   assign o_pc_src      = go && br_taken;
   assign o_flush       = go && br_taken;
   assign o_jump        = go && is_j;
   assign o_branch_addr = i_rst ? 32'd0 : (i_pc_plus4 + {imm[29:0], 2'b00});
   assign o_jump_addr   = i_rst ? 32'd0 : {i_pc_plus4[31:28], i_instr[25:0], 2'b00};

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         ex_ctrl     <= '0;
         ex_pc_plus4 <= '0;
         ex_rs_data  <= '0;
         ex_rt_data  <= '0;
         ex_imm      <= '0;
         ex_rs       <= '0;
         ex_rt       <= '0;
         ex_rd       <= '0;
      end else begin
         ex_ctrl     <= stall ? '0 : dec_ctrl;
         ex_pc_plus4 <= i_pc_plus4;
         ex_rs_data  <= rs_data;
         ex_rt_data  <= rt_data;
         ex_imm      <= imm;
         ex_rs       <= rs;
         ex_rt       <= rt;
         ex_rd       <= rd;
      end
   end

   assign o_ex_pc_plus4   = ex_pc_plus4;
   assign o_ex_rs_data    = ex_rs_data;
   assign o_ex_rt_data    = ex_rt_data;
   assign o_ex_imm        = ex_imm;
   assign o_ex_rs         = ex_rs;
   assign o_ex_rt         = ex_rt;
   assign o_ex_rd         = ex_rd;
   assign o_ex_reg_write  = ex_ctrl.reg_write;
   assign o_ex_mem_to_reg = ex_ctrl.mem_to_reg;
   assign o_ex_mem_read   = ex_ctrl.mem_read;
   assign o_ex_mem_write  = ex_ctrl.mem_write;
   assign o_ex_alu_src    = ex_ctrl.alu_src;
   assign o_ex_reg_dst    = ex_ctrl.reg_dst;
   assign o_ex_alu_op     = ex_ctrl.alu_op;

endmodule
